// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: multi-precision add sequencer that shares one external
// 8-bit combinational adder. It adds two NBYTES-wide operands one byte per
// cycle, least-significant byte first, and chains the carry between bytes.
//
// Optional feature: define ADDSEQ_SUB_EN to add the in_sub port. When in_sub
// is set at accept, the block computes in_a - in_b (out_cout=1 => no borrow).
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    request handshake; in_a, in_b, in_cin operands
//   in_sub               subtract select (ADDSEQ_SUB_EN only)
//   out_valid/out_ready  result handshake; out_sum, out_cout result
//   add_a/add_b/add_cin  operand byte and carry driven to the shared adder
//   add_sum/add_carry    shared adder result, captured while in RUN
module adder_seq_ctrl #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*NBYTES-1:0] in_a,
    input  logic [8*NBYTES-1:0] in_b,
    input  logic                in_cin,
`ifdef ADDSEQ_SUB_EN
    input  logic                in_sub,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] out_sum,
    output logic                out_cout,
    output logic [7:0]          add_a,
    output logic [7:0]          add_b,
    output logic                add_cin,
    input  logic [7:0]          add_sum,
    input  logic                add_carry
);

    localparam int unsigned W     = 8 * NBYTES;
    localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [W-1:0]       a_reg;
    logic [W-1:0]       b_reg;
    logic [W-1:0]       result;
    logic               carry_reg;
    logic [IDX_W-1:0]   idx;
    logic               last_byte;
    logic               accept;
    logic               sub_sel;

`ifdef ADDSEQ_SUB_EN
    assign sub_sel = in_sub;
`else
    assign sub_sel = 1'b0;
`endif

    assign last_byte = (idx == IDX_W'(NBYTES - 1));
    assign accept    = (state == IDLE) && in_valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last_byte) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch at accept; per-byte capture of the shared adder in RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            result    <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
        end else if (accept) begin
            a_reg     <= in_a;
            // Subtract is a + ~b + 1; the +1 rides in through the byte-0 carry.
            b_reg     <= sub_sel ? ~in_b : in_b;
            carry_reg <= sub_sel ? 1'b1 : in_cin;
            idx       <= '0;
        end else if (state == RUN) begin
            result[8*int'(idx) +: 8] <= add_sum;
            carry_reg                <= add_carry;
            idx                      <= last_byte ? '0 : idx + IDX_W'(1);
        end
    end

    // Output decode: adder bus live only in RUN, result visible only in DONE
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_sum   = '0;
        out_cout  = 1'b0;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            RUN: begin
                add_a   = a_reg[8*int'(idx) +: 8];
                add_b   = b_reg[8*int'(idx) +: 8];
                add_cin = carry_reg;
            end
            DONE: begin
                out_valid = 1'b1;
                out_sum   = result;
                out_cout  = carry_reg;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Self-checking bench for adder_seq_ctrl (NBYTES=4) with a behavioural 8-bit
// adder model and a scoreboard of expected {cout,sum} results.
module tb_adder_seq_ctrl;

    localparam int unsigned NBYTES = 4;
    localparam int unsigned W      = 8 * NBYTES;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           in_cin;
    logic           in_sub;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_sum;
    logic           out_cout;
    logic [7:0]     add_a;
    logic [7:0]     add_b;
    logic           add_cin;
    logic [7:0]     add_sum;
    logic           add_carry;

    int errors = 0;
    int checks = 0;
    logic [W:0] sb_q[$];

    adder_seq_ctrl #(.NBYTES(NBYTES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef ADDSEQ_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_carry (add_carry)
    );

    // Shared external 8-bit adder
    assign {add_carry, add_sum} = 9'(add_a) + 9'(add_b) + 9'(add_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Result monitor: one pop per output handshake
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            check("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                logic [W:0] e;
                e = sb_q.pop_front();
                check("out_sum", 64'(out_sum), 64'(e[W-1:0]));
                check("out_cout", 64'(out_cout), 64'(e[W]));
            end
        end
    end

    task automatic check_idle_bus(input string tag);
        check({tag, "_add_a"}, 64'(add_a), 64'd0);
        check({tag, "_add_b"}, 64'(add_b), 64'd0);
        check({tag, "_add_cin"}, 64'(add_cin), 64'd0);
    endtask

    // One operation: accept, per-byte adder bus checks, optional stall or reset
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input int stall, input bit hold_valid,
                          input int abort_byte);
        logic [W:0]   exp;
        logic [W-1:0] bb;
        logic         c;
        logic [8:0]   s;
        bb  = sub ? ~b : b;
        c   = sub ? 1'b1 : cin;
        exp = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
        if (abort_byte < 0) sb_q.push_back(exp);
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        in_sub    = sub;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'd1);
        check("idle_out_valid", 64'(out_valid), 64'd0);
        check_idle_bus("idle");
        @(posedge clk); #1;
        if (!hold_valid) in_valid = 1'b0;
        for (int i = 0; i < int'(NBYTES); i++) begin
            @(negedge clk);
            s = 9'(a[8*i +: 8]) + 9'(bb[8*i +: 8]) + 9'(c);
            check("run_add_a", 64'(add_a), 64'(a[8*i +: 8]));
            check("run_add_b", 64'(add_b), 64'(bb[8*i +: 8]));
            check("run_add_cin", 64'(add_cin), 64'(c));
            check("run_in_ready", 64'(in_ready), 64'd0);
            check("run_out_valid", 64'(out_valid), 64'd0);
            if (i == 0) check("run_out_sum0", 64'(out_sum), 64'd0);
            if (i == abort_byte) begin
                rst_n = 1'b0;
                #1;
                check("rst_in_ready", 64'(in_ready), 64'd1);
                check("rst_out_valid", 64'(out_valid), 64'd0);
                check("rst_out_sum", 64'(out_sum), 64'd0);
                check("rst_out_cout", 64'(out_cout), 64'd0);
                check_idle_bus("rst");
                in_valid = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            c = s[8];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("done_out_valid", 64'(out_valid), 64'd1);
        check("done_in_ready", 64'(in_ready), 64'd0);
        check_idle_bus("done");
        for (int j = 0; j < stall; j++) begin
            check("stall_sum", 64'(out_sum), 64'(exp[W-1:0]));
            check("stall_cout", 64'(out_cout), 64'(exp[W]));
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
            if (j == stall - 1) out_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        check("ret_in_ready", 64'(in_ready), 64'd1);
        check("ret_out_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b1;
        #3;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_sum", 64'(out_sum), 64'd0);
        check("reset_out_cout", 64'(out_cout), 64'd0);
        check_idle_bus("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 0, 1'b0, -1);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0, -1);
        run_op(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 0, 1'b1, -1);
        run_op(32'hA5A5_A5A5, 32'h5A5A_5A5B, 1'b0, 1'b0, 5, 1'b0, -1);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 0, 1'b0, -1);
        run_op(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 1'b0, 0, 1'b0, 2);
        run_op(32'd100, 32'd10, 1'b1, 1'b0, 0, 1'b0, -1);
`ifdef ADDSEQ_SUB_EN
        run_op(32'd100, 32'd10, 1'b0, 1'b1, 0, 1'b0, -1);
        run_op(32'd10, 32'd100, 1'b1, 1'b1, 0, 1'b0, -1);
        run_op(32'hFFFF_0000, 32'h0001_0001, 1'b0, 1'b0, 1, 1'b0, -1);
`endif
        for (int k = 0; k < 6; k++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0,
                   int'($urandom_range(0, 3)), 1'b0, -1);
        end
        repeat (3) @(posedge clk);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
